// File: rtl/adc_capture_if.sv
`default_nettype none
// ============================================================================
// Module   : adc_capture_if
// Purpose  : Bundles the ADC serial pins, the sample-RAM write port and the
//            frame valid/ack handshake of adc_capture_ctrl.
// Modports : master - capture controller (drives ADC pins, write port, frame
//                     status; receives dout and frame_ack)
//            slave  - ADC + sample RAM + FFT loader side
// Signals  : ad_clk, cs, din, dout        ADC serial link (cs active low)
//            wr_en, wr_addr, wr_data      sample write strobe {bank, index}
//            frame_valid, frame_bank,     completed-frame handshake
//            frame_ack, overrun
// Revision : 1.0 - initial release
// ============================================================================
interface adc_capture_if #(
    parameter int IDX_W = 6
);
    logic             ad_clk;
    logic             cs;
    logic             din;
    logic             dout;
    logic             wr_en;
    logic [IDX_W:0]   wr_addr;
    logic [9:0]       wr_data;
    logic             frame_valid;
    logic             frame_bank;
    logic             frame_ack;
    logic             overrun;

    modport master (
        output ad_clk, cs, din, wr_en, wr_addr, wr_data,
               frame_valid, frame_bank, overrun,
        input  dout, frame_ack
    );

    modport slave (
        input  ad_clk, cs, din, wr_en, wr_addr, wr_data,
               frame_valid, frame_bank, overrun,
        output dout, frame_ack
    );
endinterface
`default_nettype wire

// File: rtl/adc_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : adc_capture_ctrl
// Purpose  : Sequences an MCP300x-style 10-bit SPI ADC (START/SGL/D2..D0),
//            captures back-to-back conversions into a ping-pong buffer of
//            2 x NUM_SAMPLES words and hands completed frames to the FFT
//            loader with a valid/ack handshake.
// Ports    : clk, rst        clock, asynchronous active-high reset
//            run             level, 1 = convert continuously
//            channel         D2..D0 channel select, latched at conversion start
//            single_ended    SGL bit, latched at conversion start
//            busy            high while converting or in the cs-high gap
//            bus (master)    ADC pins, sample write port, frame handshake
// Revision : 1.0 - initial release
// ============================================================================
module adc_capture_ctrl #(
    parameter int SCLK_HALF     = 75,
    parameter int NUM_SAMPLES   = 64,
    parameter int CS_HIGH_SLOTS = 2,
    parameter int IDX_W         = $clog2(NUM_SAMPLES)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         run,
    input  logic [2:0]   channel,
    input  logic         single_ended,
    output logic         busy,
    adc_capture_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    localparam int c_CYC_W    = $clog2(2 * SCLK_HALF);
    localparam int c_SLOT_MAX = (CS_HIGH_SLOTS > 17) ? CS_HIGH_SLOTS : 17;
    localparam int c_SLOT_W   = $clog2(c_SLOT_MAX);

    localparam logic [c_CYC_W-1:0]  c_CYC_LAST   = c_CYC_W'(2 * SCLK_HALF - 1);
    localparam logic [c_CYC_W-1:0]  c_CYC_HIGH   = c_CYC_W'(SCLK_HALF);
    localparam logic [c_SLOT_W-1:0] c_CONV_LAST  = c_SLOT_W'(16);
    localparam logic [c_SLOT_W-1:0] c_GAP_LAST   = c_SLOT_W'(CS_HIGH_SLOTS - 1);
    localparam logic [c_SLOT_W-1:0] c_FIRST_DATA = c_SLOT_W'(7);
    localparam logic [IDX_W-1:0]    c_IDX_LAST   = IDX_W'(NUM_SAMPLES - 1);

    state_t              r_state, w_state_nxt;
    logic [c_CYC_W-1:0]  r_cyc, w_cyc_nxt;
    logic [c_SLOT_W-1:0] r_slot, w_slot_nxt;
    logic                w_slot_end;
    logic                w_latch;
    logic                w_enter_idle;
    logic                w_sample_b0;
    logic                w_shift_en;
    logic                w_cs_nxt, w_ad_clk_nxt, w_din_nxt;

    logic [2:0]          r_channel;
    logic                r_sgl;
    logic [8:0]          r_shift;
    logic [IDX_W-1:0]    r_idx;
    logic                r_bank;
    logic                r_cs, r_ad_clk, r_din, r_busy;
    logic                r_wr_en;
    logic [IDX_W:0]      r_wr_addr;
    logic [9:0]          r_wr_data;
    logic                r_fv, r_fb, r_overrun;

    // ------------------------------------------------------------------
    // Next-state, slot/cycle counters and next values of the pin outputs.
    // Pins are registered from the next-state decode so they toggle exactly
    // at slot boundaries without combinational glitches.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_cyc_nxt    = r_cyc;
        w_slot_nxt   = r_slot;
        w_latch      = 1'b0;
        w_enter_idle = 1'b0;
        w_slot_end   = (r_cyc == c_CYC_LAST);

        case (r_state)
            S_IDLE: begin
                if (run) begin
                    w_state_nxt = S_CONV;
                    w_cyc_nxt   = '0;
                    w_slot_nxt  = '0;
                    w_latch     = 1'b1;
                end
            end
            S_CONV: begin
                if (w_slot_end) begin
                    w_cyc_nxt = '0;
                    if (r_slot == c_CONV_LAST) begin
                        w_state_nxt = S_GAP;
                        w_slot_nxt  = '0;
                    end else begin
                        w_slot_nxt = r_slot + 1'b1;
                    end
                end else begin
                    w_cyc_nxt = r_cyc + 1'b1;
                end
            end
            S_GAP: begin
                if (w_slot_end) begin
                    w_cyc_nxt  = '0;
                    w_slot_nxt = '0;
                    if (r_slot == c_GAP_LAST) begin
                        if (run) begin
                            w_state_nxt = S_CONV;
                            w_latch     = 1'b1;
                        end else begin
                            w_state_nxt  = S_IDLE;
                            w_enter_idle = 1'b1;
                        end
                    end else begin
                        w_slot_nxt = r_slot + 1'b1;
                    end
                end else begin
                    w_cyc_nxt = r_cyc + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cyc_nxt   = '0;
                w_slot_nxt  = '0;
            end
        endcase

        w_cs_nxt     = (w_state_nxt != S_CONV);
        w_ad_clk_nxt = (w_state_nxt == S_CONV) && (w_cyc_nxt >= c_CYC_HIGH);

        // Slot 0 (START) never needs the latched command, so the latch and
        // the first din bit can happen on the same edge.
        w_din_nxt = 1'b0;
        if (w_state_nxt == S_CONV) begin
            case (w_slot_nxt)
                c_SLOT_W'(0): w_din_nxt = 1'b1;
                c_SLOT_W'(1): w_din_nxt = r_sgl;
                c_SLOT_W'(2): w_din_nxt = r_channel[2];
                c_SLOT_W'(3): w_din_nxt = r_channel[1];
                c_SLOT_W'(4): w_din_nxt = r_channel[0];
                default:      w_din_nxt = 1'b0;
            endcase
        end

        // dout is taken on the last cycle of each high half; B9..B0 live in
        // slots 7..16, so the final sample is the one in slot 16.
        w_shift_en  = (r_state == S_CONV) && w_slot_end && (r_slot >= c_FIRST_DATA);
        w_sample_b0 = (r_state == S_CONV) && w_slot_end && (r_slot == c_CONV_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cyc     <= '0;
            r_slot    <= '0;
            r_cs      <= 1'b1;
            r_ad_clk  <= 1'b0;
            r_din     <= 1'b0;
            r_busy    <= 1'b0;
            r_channel <= '0;
            r_sgl     <= 1'b0;
            r_shift   <= '0;
            r_idx     <= '0;
            r_bank    <= 1'b0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_fv      <= 1'b0;
            r_fb      <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cyc    <= w_cyc_nxt;
            r_slot   <= w_slot_nxt;
            r_cs     <= w_cs_nxt;
            r_ad_clk <= w_ad_clk_nxt;
            r_din    <= w_din_nxt;
            r_busy   <= (w_state_nxt != S_IDLE);

            if (w_latch) begin
                r_channel <= channel;
                r_sgl     <= single_ended;
            end

            if (w_shift_en) begin
                r_shift <= {r_shift[7:0], bus.dout};
            end

            r_wr_en   <= w_sample_b0;
            r_overrun <= 1'b0;

            if (w_sample_b0) begin
                r_wr_data <= {r_shift, bus.dout};
                r_wr_addr <= {r_bank, r_idx};
                if (r_idx == c_IDX_LAST) begin
                    r_idx <= '0;
                    // A same-cycle ack frees the pending frame first, so the
                    // new frame is handed over instead of being dropped.
                    if (r_fv && !bus.frame_ack) begin
                        r_overrun <= 1'b1;
                    end else begin
                        r_fv   <= 1'b1;
                        r_fb   <= r_bank;
                        r_bank <= ~r_bank;
                    end
                end else begin
                    r_idx <= r_idx + 1'b1;
                    if (r_fv && bus.frame_ack) begin
                        r_fv <= 1'b0;
                    end
                end
            end else begin
                if (r_fv && bus.frame_ack) begin
                    r_fv <= 1'b0;
                end
                // Stopping discards the partial frame; the bank is kept.
                if (w_enter_idle) begin
                    r_idx <= '0;
                end
            end
        end
    end

    assign bus.ad_clk      = r_ad_clk;
    assign bus.cs          = r_cs;
    assign bus.din         = r_din;
    assign bus.wr_en       = r_wr_en;
    assign bus.wr_addr     = r_wr_addr;
    assign bus.wr_data     = r_wr_data;
    assign bus.frame_valid = r_fv;
    assign bus.frame_bank  = r_fb;
    assign bus.overrun     = r_overrun;
    assign busy            = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_adc_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_capture_ctrl
// Purpose  : Scoreboard bench for adc_capture_ctrl. An ADC model answers each
//            conversion with a random sample and predicts the resulting write
//            and frame status; a monitor checks every wr_en against it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adc_capture_ctrl;

    localparam int SCLK_HALF     = 2;
    localparam int NUM_SAMPLES   = 4;
    localparam int CS_HIGH_SLOTS = 2;
    localparam int IDX_W         = $clog2(NUM_SAMPLES);
    localparam int PERIOD_CLK    = (17 + CS_HIGH_SLOTS) * 2 * SCLK_HALF;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b1;
    logic [2:0] channel;
    logic       single_ended;
    logic       busy;

    adc_capture_if #(.IDX_W(IDX_W)) bus ();

    adc_capture_ctrl #(
        .SCLK_HALF    (SCLK_HALF),
        .NUM_SAMPLES  (NUM_SAMPLES),
        .CS_HIGH_SLOTS(CS_HIGH_SLOTS),
        .IDX_W        (IDX_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .channel     (channel),
        .single_ended(single_ended),
        .busy        (busy),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IDX_W:0] addr;
        logic [9:0]     data;
        logic           ovr;
        logic           fv;
        logic           fb;
    } exp_t;

    exp_t sb[$];

    int vectors = 0;
    int errors  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Reference state: where the next sample lands and the frame status.
    int   m_idx, m_bank, m_fv, m_fb;
    bit   idle_pending;
    int   conv_num = 0;
    int   cur_slot = 0;

    // ADC model / stimulus
    int         cyc_now = 0, last_fall = 0, rises = 0, hi_cnt = 0;
    bit         have_fall, run_was_low, ack_chk, prev_cs = 1'b1, prev_adclk;
    logic [2:0] exp_ch;
    logic       exp_sgl;
    logic [9:0] sample;

    function automatic logic din_for_slot(input int s);
        case (s)
            0:       return 1'b1;
            1:       return exp_sgl;
            2:       return exp_ch[2];
            3:       return exp_ch[1];
            4:       return exp_ch[0];
            default: return 1'b0;
        endcase
    endfunction

    always @(negedge clk) begin
        exp_t e;
        cyc_now++;
        if (rst) begin
            prev_cs       = 1'b1;
            prev_adclk    = 1'b0;
            rises         = 0;
            cur_slot      = 0;
            hi_cnt        = 0;
            have_fall     = 1'b0;
            run_was_low   = 1'b0;
            ack_chk       = 1'b0;
            bus.frame_ack = 1'b0;
            bus.dout      = 1'b0;
            channel       = 3'd5;
            single_ended  = 1'b1;
            m_idx = 0; m_bank = 0; m_fv = 0; m_fb = 0;
            idle_pending  = 1'b0;
        end else begin
            if (ack_chk) begin
                bus.frame_ack = 1'b0;
                ack_chk = 1'b0;
                check("frame_valid_after_ack", 32'(bus.frame_valid), 32'(m_fv));
            end
            if (!run) run_was_low = 1'b1;

            if (prev_cs && !bus.cs) begin
                if (have_fall && !run_was_low)
                    check("conv_period", 32'(cyc_now - last_fall), 32'(PERIOD_CLK));
                have_fall   = 1'b1;
                last_fall   = cyc_now;
                run_was_low = 1'b0;
                conv_num++;
                rises    = 0;
                cur_slot = 0;
                exp_ch   = channel;
                exp_sgl  = single_ended;
                channel      = 3'($urandom);
                single_ended = 1'($urandom);
                sample   = (conv_num == 1) ? 10'h2A5 : 10'($urandom);
                if (idle_pending) begin
                    m_idx = 0;
                    idle_pending = 1'b0;
                end
            end

            if (!bus.cs && bus.ad_clk && !prev_adclk) begin
                cur_slot = rises;
                rises++;
                hi_cnt = 0;
                check($sformatf("din_slot%0d", cur_slot), 32'(bus.din), 32'(din_for_slot(cur_slot)));
                bus.dout = (cur_slot >= 7) ? sample[16 - cur_slot] : 1'($urandom);
            end else if (!bus.cs && bus.ad_clk) begin
                hi_cnt++;
            end

            // Mid-conversion acknowledge of the pending frame.
            if (!bus.cs && bus.ad_clk && cur_slot == 10 && hi_cnt == 0 && conv_num == 13) begin
                bus.frame_ack = 1'b1;
                ack_chk = 1'b1;
                m_fv = 0;
            end

            // Cycle in which B0 is taken: predict the write and frame status.
            if (!bus.cs && bus.ad_clk && cur_slot == 16 && hi_cnt == SCLK_HALF - 1) begin
                if (conv_num == 12) begin
                    bus.frame_ack = 1'b1;
                    ack_chk = 1'b1;
                    m_fv = 0;
                end
                e.addr = {1'(m_bank), IDX_W'(m_idx)};
                e.data = sample;
                e.ovr  = 1'b0;
                if (m_idx == NUM_SAMPLES - 1) begin
                    if (m_fv != 0) begin
                        e.ovr = 1'b1;
                    end else begin
                        m_fv   = 1;
                        m_fb   = m_bank;
                        m_bank = 1 - m_bank;
                    end
                end
                m_idx = (m_idx + 1) % NUM_SAMPLES;
                e.fv = 1'(m_fv);
                e.fb = 1'(m_fb);
                sb.push_back(e);
            end

            if (!prev_cs && bus.cs)
                check("adclk_rises_per_cs_low", 32'(rises), 32'd17);

            prev_cs    = bus.cs;
            prev_adclk = bus.ad_clk;
        end
    end

    // Monitor
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (bus.wr_en) begin
                if (sb.size() == 0) begin
                    check("unexpected_wr_en", 32'(bus.wr_en), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("wr_addr",     32'(bus.wr_addr),     32'(e.addr));
                    check("wr_data",     32'(bus.wr_data),     32'(e.data));
                    check("overrun",     32'(bus.overrun),     32'(e.ovr));
                    check("frame_valid", 32'(bus.frame_valid), 32'(e.fv));
                    check("frame_bank",  32'(bus.frame_bank),  32'(e.fb));
                end
            end else begin
                check("overrun_without_write", 32'(bus.overrun), 32'd0);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b1;
        run = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_cs",          32'(bus.cs),          32'd1);
        check("reset_ad_clk",      32'(bus.ad_clk),      32'd0);
        check("reset_busy",        32'(busy),            32'd0);
        check("reset_frame_valid", 32'(bus.frame_valid), 32'd0);
        check("reset_wr_en",       32'(bus.wr_en),       32'd0);
        check("reset_din",         32'(bus.din),         32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("cs_falls_after_release", 32'(bus.cs), 32'd0);

        // Drop run during slot 3 of the conversion for index 2.
        n = 0;
        while (!(conv_num == 15 && m_idx == 2 && cur_slot == 3 && !bus.cs) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("wait_run_drop_point", 32'(n < 3000), 32'd1);
        run = 1'b0;
        idle_pending = 1'b1;

        n = 0;
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("busy_low_after_stop", 32'(busy),   32'd0);
        check("cs_high_after_stop",  32'(bus.cs), 32'd1);
        check("scoreboard_drained",  32'(sb.size()), 32'd0);

        repeat (10) @(negedge clk);
        run = 1'b1;

        // Asynchronous reset mid-slot 10 of the second conversion after restart.
        n = 0;
        while (!(conv_num == 17 && cur_slot == 10 && !bus.cs) && n < 600) begin
            @(negedge clk);
            n++;
        end
        check("wait_reset_point", 32'(n < 600), 32'd1);
        #1;
        rst = 1'b1;
        run = 1'b0;
        #1;
        check("async_rst_cs",          32'(bus.cs),          32'd1);
        check("async_rst_ad_clk",      32'(bus.ad_clk),      32'd0);
        check("async_rst_busy",        32'(busy),            32'd0);
        check("async_rst_wr_en",       32'(bus.wr_en),       32'd0);
        check("async_rst_frame_valid", 32'(bus.frame_valid), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("idle_cs_after_reset", 32'(bus.cs), 32'd1);
        check("no_pending_writes",   32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
